// File: rtl/bundler_seq_ctrl.sv
// Serial majority bundler: accumulates NUM_HVS hypervectors one per handshake into
// per-dimension ones counters, resolves the majority vote, and holds the result until consumed.
module bundler_seq_ctrl #(
   parameter int                    DIMENSIONS = 10000,
   parameter int                    NUM_HVS    = 17,
   parameter int                    CNT_W      = $clog2(NUM_HVS + 1),
   parameter logic [DIMENSIONS-1:0] TIE_SEED   = {DIMENSIONS/2{2'b01}}
) (
   input  logic                  clk,
   input  logic                  nrst,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DIMENSIONS-1:0] in_hv,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DIMENSIONS-1:0] out_hv,
   output logic [CNT_W-1:0]      acc_count
);

   typedef enum logic [1:0] {ACCUM, RESOLVE, HOLD} state_t;

   localparam logic [CNT_W-1:0] HALF_C = CNT_W'(NUM_HVS / 2);
   localparam logic [CNT_W-1:0] LAST_C = CNT_W'(NUM_HVS - 1);
   localparam bit               ODD_N  = (NUM_HVS % 2) == 1;

   state_t                  state_q, state_d;
   logic [CNT_W-1:0]        cnt_q [DIMENSIONS];
   logic [CNT_W-1:0]        cnt_d [DIMENSIONS];
   logic [CNT_W-1:0]        acc_q, acc_d;
   logic [DIMENSIONS-1:0]   out_hv_q, out_hv_d;
   logic                    out_valid_q, out_valid_d;
   logic [DIMENSIONS-1:0]   tie_q, tie_d;

   // For odd bundle sizes a tie cannot occur, so the tie bit is never consulted.
   function automatic logic maj_bit(input logic [CNT_W-1:0] c, input logic tie);
      if (ODD_N)            return c > HALF_C;
      else if (c > HALF_C)  return 1'b1;
      else if (c < HALF_C)  return 1'b0;
      else                  return tie;
   endfunction

   assign in_ready  = (state_q == ACCUM) && !nrst;
   assign out_valid = out_valid_q;
   assign out_hv    = out_hv_q;
   assign acc_count = acc_q;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      acc_d       = acc_q;
      out_hv_d    = out_hv_q;
      out_valid_d = out_valid_q;
      tie_d       = tie_q;
      if (flush) begin
         for (int i = 0; i < DIMENSIONS; i++) cnt_d[i] = '0;
         acc_d       = '0;
         out_valid_d = 1'b0;
         state_d     = ACCUM;
      end else begin
         case (state_q)
            ACCUM: begin
               if (in_valid && in_ready) begin
                  for (int i = 0; i < DIMENSIONS; i++)
                     cnt_d[i] = cnt_q[i] + {{(CNT_W-1){1'b0}}, in_hv[i]};
                  acc_d = acc_q + 1'b1;
                  if (acc_q == LAST_C) state_d = RESOLVE;
               end
            end
            RESOLVE: begin
               for (int i = 0; i < DIMENSIONS; i++) begin
                  out_hv_d[i] = maj_bit(cnt_q[i], tie_q[i]);
                  cnt_d[i]    = '0;
               end
               acc_d       = '0;
               out_valid_d = 1'b1;
               state_d     = HOLD;
            end
            HOLD: begin
               if (out_ready) begin
                  out_valid_d = 1'b0;
                  tie_d       = {tie_q[DIMENSIONS-2:0], tie_q[DIMENSIONS-1]};
                  state_d     = ACCUM;
               end
            end
            default: state_d = ACCUM;
         endcase
      end
   end

   always_ff @(posedge clk or posedge nrst) begin
      if (nrst) begin
         state_q     <= ACCUM;
         for (int i = 0; i < DIMENSIONS; i++) cnt_q[i] <= '0;
         acc_q       <= '0;
         out_hv_q    <= '0;
         out_valid_q <= 1'b0;
         tie_q       <= TIE_SEED;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         acc_q       <= acc_d;
         out_hv_q    <= out_hv_d;
         out_valid_q <= out_valid_d;
         tie_q       <= tie_d;
      end
   end

endmodule

// File: tb/tb_bundler_seq_ctrl.sv
// Bench for bundler_seq_ctrl: three configurations share one stimulus stream and are
// compared every cycle against a bundle-level reference model.
module tb_bundler_seq_ctrl;

   logic       clk = 1'b0;
   logic       nrst, flush, in_valid, out_ready;
   logic [7:0] in_hv;

   logic       rdy_a, ov_a, rdy_b, ov_b, rdy_c, ov_c;
   logic [7:0] hv_a, hv_b, hv_c;
   logic [1:0] cnt_a, cnt_b;
   logic [4:0] cnt_c;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   bundler_seq_ctrl #(.DIMENSIONS(8), .NUM_HVS(3)) u_a (
      .clk(clk), .nrst(nrst), .flush(flush), .in_valid(in_valid), .in_ready(rdy_a),
      .in_hv(in_hv), .out_valid(ov_a), .out_ready(out_ready), .out_hv(hv_a), .acc_count(cnt_a));

   bundler_seq_ctrl #(.DIMENSIONS(8), .NUM_HVS(2), .TIE_SEED(8'hA5)) u_b (
      .clk(clk), .nrst(nrst), .flush(flush), .in_valid(in_valid), .in_ready(rdy_b),
      .in_hv(in_hv), .out_valid(ov_b), .out_ready(out_ready), .out_hv(hv_b), .acc_count(cnt_b));

   bundler_seq_ctrl #(.DIMENSIONS(8), .NUM_HVS(17)) u_c (
      .clk(clk), .nrst(nrst), .flush(flush), .in_valid(in_valid), .in_ready(rdy_c),
      .in_hv(in_hv), .out_valid(ov_c), .out_ready(out_ready), .out_hv(hv_c), .acc_count(cnt_c));

   // Reference model: per instance, the list of accepted vectors plus the bundle phase.
   localparam int         NH   [3] = '{3, 2, 17};
   localparam logic [7:0] SEED [3] = '{8'h55, 8'hA5, 8'h55};

   int         m_ph  [3];   // 0 collecting, 1 resolving, 2 presenting
   int         m_n   [3];
   logic [7:0] m_v   [3][17];
   logic [7:0] m_out [3];
   logic       m_ov  [3];
   logic [7:0] m_tie [3];

   task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s @%0t got=0x%0h exp=0x%0h", tag, $time, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 3; k++) begin
         m_ph[k]  = 0;
         m_n[k]   = 0;
         m_ov[k]  = 1'b0;
         m_out[k] = 8'h00;
         m_tie[k] = SEED[k];
      end
   endtask

   task automatic model_step();
      int c;
      for (int k = 0; k < 3; k++) begin
         if (flush) begin
            m_n[k]  = 0;
            m_ph[k] = 0;
            m_ov[k] = 1'b0;
         end else if (m_ph[k] == 0) begin
            if (in_valid) begin
               m_v[k][m_n[k]] = in_hv;
               m_n[k]++;
               if (m_n[k] == NH[k]) m_ph[k] = 1;
            end
         end else if (m_ph[k] == 1) begin
            for (int b = 0; b < 8; b++) begin
               c = 0;
               for (int j = 0; j < NH[k]; j++) c += int'(m_v[k][j][b]);
               if (2 * c > NH[k])      m_out[k][b] = 1'b1;
               else if (2 * c < NH[k]) m_out[k][b] = 1'b0;
               else                    m_out[k][b] = m_tie[k][b];
            end
            m_ov[k] = 1'b1;
            m_n[k]  = 0;
            m_ph[k] = 2;
         end else if (out_ready) begin
            m_ov[k]  = 1'b0;
            m_ph[k]  = 0;
            m_tie[k] = {m_tie[k][6:0], m_tie[k][7]};
         end
      end
   endtask

   task automatic check_all();
      chk_eq("a_in_ready",  32'(rdy_a), 32'(m_ph[0] == 0 && !nrst));
      chk_eq("a_out_valid", 32'(ov_a),  32'(m_ov[0]));
      chk_eq("a_out_hv",    32'(hv_a),  32'(m_out[0]));
      chk_eq("a_acc_count", 32'(cnt_a), 32'(m_n[0]));
      chk_eq("b_in_ready",  32'(rdy_b), 32'(m_ph[1] == 0 && !nrst));
      chk_eq("b_out_valid", 32'(ov_b),  32'(m_ov[1]));
      chk_eq("b_out_hv",    32'(hv_b),  32'(m_out[1]));
      chk_eq("b_acc_count", 32'(cnt_b), 32'(m_n[1]));
      chk_eq("c_in_ready",  32'(rdy_c), 32'(m_ph[2] == 0 && !nrst));
      chk_eq("c_out_valid", 32'(ov_c),  32'(m_ov[2]));
      chk_eq("c_out_hv",    32'(hv_c),  32'(m_out[2]));
      chk_eq("c_acc_count", 32'(cnt_c), 32'(m_n[2]));
   endtask

   task automatic drv(input logic v, input logic [7:0] d, input logic r, input logic f);
      in_valid  = v;
      in_hv     = d;
      out_ready = r;
      flush     = f;
   endtask

   // Advance one clock: model computes the post-edge state from the inputs now applied.
   task automatic cycle();
      if (nrst) model_reset();
      else      model_step();
      @(posedge clk);
      @(negedge clk);
      check_all();
   endtask

   initial begin
      nrst = 1'b1;
      drv(1'b0, 8'h00, 1'b0, 1'b0);
      model_reset();
      @(negedge clk);
      @(negedge clk);
      check_all();
      chk_eq("rst_in_ready", 32'(rdy_a), 32'd0);
      chk_eq("rst_out_hv",   32'(hv_a),  32'd0);
      nrst = 1'b0;
      #1;
      check_all();

      // Three-vector bundle, acc_count 1,2,3 then 0 with out_valid.
      drv(1'b1, 8'h0F, 1'b0, 1'b0); cycle(); chk_eq("dir_cnt1", 32'(cnt_a), 32'd1);
      drv(1'b1, 8'h3C, 1'b0, 1'b0); cycle(); chk_eq("dir_cnt2", 32'(cnt_a), 32'd2);
      drv(1'b1, 8'hF0, 1'b0, 1'b0); cycle(); chk_eq("dir_cnt3", 32'(cnt_a), 32'd3);
      chk_eq("dir_ov_early", 32'(ov_a), 32'd0);
      drv(1'b0, 8'h00, 1'b0, 1'b0); cycle();
      chk_eq("dir_cnt0", 32'(cnt_a), 32'd0);
      chk_eq("dir_ov",   32'(ov_a),  32'd1);
      chk_eq("dir_hv",   32'(hv_a),  32'h3C);

      // Backpressure: output held, input pulses ignored.
      for (int i = 0; i < 5; i++) begin
         drv(1'(i % 2), 8'($urandom), 1'b0, 1'b0);
         cycle();
         chk_eq("bp_hv",  32'(hv_a),  32'h3C);
         chk_eq("bp_rdy", 32'(rdy_a), 32'd0);
      end
      drv(1'b0, 8'h00, 1'b1, 1'b0); cycle();
      chk_eq("bp_done_ov",  32'(ov_a),  32'd0);
      chk_eq("bp_done_rdy", 32'(rdy_a), 32'd1);
      chk_eq("bp_done_cnt", 32'(cnt_a), 32'd0);

      // Flush discards the partial bundle and the coincident vector.
      drv(1'b0, 8'h00, 1'b0, 1'b1); cycle();
      drv(1'b1, 8'hFF, 1'b0, 1'b0); cycle(); chk_eq("fl_cnt1", 32'(cnt_a), 32'd1);
      drv(1'b1, 8'hFF, 1'b0, 1'b1); cycle(); chk_eq("fl_cnt0", 32'(cnt_a), 32'd0);
      drv(1'b1, 8'h01, 1'b0, 1'b0); cycle();
      drv(1'b1, 8'h01, 1'b0, 1'b0); cycle();
      drv(1'b1, 8'h00, 1'b0, 1'b0); cycle();
      drv(1'b0, 8'h00, 1'b0, 1'b0); cycle();
      chk_eq("fl_ov", 32'(ov_a), 32'd1);
      chk_eq("fl_hv", 32'(hv_a), 32'h01);

      // Seventeen-vector bundles: counters reach 17 without wrapping.
      drv(1'b0, 8'h00, 1'b0, 1'b1); cycle();
      for (int i = 0; i < 17; i++) begin
         drv(1'b1, 8'hFF, 1'b0, 1'b0);
         cycle();
      end
      chk_eq("n17_cnt", 32'(cnt_c), 32'd17);
      drv(1'b0, 8'h00, 1'b0, 1'b0); cycle();
      chk_eq("n17_ov", 32'(ov_c), 32'd1);
      chk_eq("n17_hv", 32'(hv_c), 32'hFF);
      drv(1'b0, 8'h00, 1'b1, 1'b0); cycle();
      for (int i = 0; i < 17; i++) begin
         drv(1'b1, (i < 8) ? 8'hFF : 8'h00, 1'b0, 1'b0);
         cycle();
      end
      chk_eq("n17_cnt2", 32'(cnt_c), 32'd17);
      drv(1'b0, 8'h00, 1'b0, 1'b0); cycle();
      chk_eq("n17_hv2", 32'(hv_c), 32'h00);
      chk_eq("n17_ov2", 32'(ov_c), 32'd1);

      // Asynchronous reset while the three-vector instance is holding a result.
      chk_eq("hold_before_rst", 32'(ov_a), 32'd1);
      #2 nrst = 1'b1;
      #1 model_reset();
      check_all();
      chk_eq("arst_ov",  32'(ov_a),  32'd0);
      chk_eq("arst_hv",  32'(hv_a),  32'd0);
      chk_eq("arst_rdy", 32'(rdy_a), 32'd0);
      cycle();
      nrst = 1'b0;
      #1;
      check_all();
      chk_eq("arst_rel_rdy", 32'(rdy_a), 32'd1);

      // Even bundle size: ties come from the rotating tie vector.
      drv(1'b1, 8'hFF, 1'b0, 1'b0); cycle();
      drv(1'b1, 8'h0F, 1'b0, 1'b0); cycle();
      drv(1'b0, 8'h00, 1'b0, 1'b0); cycle();
      chk_eq("tie_hv1", 32'(hv_b), 32'hAF);
      drv(1'b0, 8'h00, 1'b1, 1'b0); cycle();
      drv(1'b1, 8'hFF, 1'b0, 1'b0); cycle();
      drv(1'b1, 8'h0F, 1'b0, 1'b0); cycle();
      drv(1'b0, 8'h00, 1'b0, 1'b0); cycle();
      chk_eq("tie_hv2", 32'(hv_b), 32'h4F);

      // Randomized traffic with occasional flushes and asynchronous resets.
      for (int it = 0; it < 3000; it++) begin
         if (nrst) begin
            nrst = 1'b0;
            #1;
            check_all();
         end else if ($urandom_range(0, 199) == 0) begin
            #2 nrst = 1'b1;
            #1 model_reset();
            check_all();
         end
         drv($urandom_range(0, 3) != 0, 8'($urandom), 1'($urandom_range(0, 1)),
             $urandom_range(0, 31) == 0);
         cycle();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
